btn_press_filter: RTL and testbench

Downstream consumer of the registered button level produced by the button state-delay flip-flop. Synchronises that level, rejects bounce with a cycle-count qualifier, and converts qualified transitions into single-cycle press, release and long-press events plus a clean held level. It also keeps a wrapping count of accepted presses. Display and mode-control logic use these outputs directly.

---
 rtl/btn_press_filter_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/btn_press_filter.sv | 140 ++++++++++++++
 tb/tb_btn_press_filter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/btn_press_filter_pkg.sv
// Shared definitions for the push-button blocks: FSM state encoding and
// default timing constants for a 100 MHz clock.
package btn_press_filter_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ARMING    = 3'd1,
      PRESSED   = 3'd2,
      LONG      = 3'd3,
      RELEASING = 3'd4
   } btn_fsm_e;

   // 5 ms debounce, 1 s long press at 100 MHz
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_LONG_CYCLES     = 100000000;
   localparam int unsigned DEF_CNT_W           = 32;

endpackage

// File: rtl/sync_2ff.sv
// One-bit two-stage synchroniser with asynchronous active-low reset.
module sync_2ff (
   input  logic gclk,
   input  logic grst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/btn_press_filter.sv
// Debounces a synchronised button level and emits one-cycle press, release and
// long-press events, a clean held level and a wrapping press counter.
module btn_press_filter
   import btn_press_filter_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic       CLOCK,
   input  logic       RESETN,
   input  logic       btn_state,
   output logic       held,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

   logic             btn_s;
   btn_fsm_e         state_q, state_d;
   logic [CNT_W-1:0] deb_q, deb_d;
   logic [CNT_W-1:0] long_q, long_d;
   logic             from_long_q, from_long_d;
   logic             held_d, press_d, rel_d, lp_d;
   logic [7:0]       cnt_d;
   logic             long_hit;

   sync_2ff u_sync (
      .gclk   (CLOCK),
      .grst_n (RESETN),
      .d      (btn_state),
      .q      (btn_s)
   );

   assign long_hit = (long_q == LONG_LAST);

   always_comb begin
      state_d     = state_q;
      deb_d       = deb_q;
      long_d      = long_q;
      from_long_d = from_long_q;
      held_d      = held;
      press_d     = 1'b0;
      rel_d       = 1'b0;
      lp_d        = 1'b0;
      cnt_d       = press_count;

      // hold counter runs until a press has gone long, bounces included
      if ((state_q == PRESSED || (state_q == RELEASING && !from_long_q)) && !long_hit)
         long_d = long_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = ARMING;
               deb_d   = '0;
            end
         end
         ARMING: begin
            if (!btn_s) begin
               state_d = IDLE;
            end else if (deb_q == DEB_LAST) begin
               state_d = PRESSED;
               press_d = 1'b1;
               held_d  = 1'b1;
               cnt_d   = press_count + 8'd1;
               long_d  = '0;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d     = RELEASING;
               deb_d       = '0;
               from_long_d = long_hit;
               lp_d        = long_hit;
            end else if (long_hit) begin
               state_d = LONG;
               lp_d    = 1'b1;
            end
         end
         LONG: begin
            if (!btn_s) begin
               state_d     = RELEASING;
               deb_d       = '0;
               from_long_d = 1'b1;
            end
         end
         RELEASING: begin
            if (btn_s) begin
               if (from_long_q || long_hit) state_d = LONG;
               else                         state_d = PRESSED;
               lp_d = !from_long_q && long_hit;
            end else if (deb_q == DEB_LAST) begin
               // an accepted release wins over a same-cycle long hit
               state_d = IDLE;
               rel_d   = 1'b1;
               held_d  = 1'b0;
            end else begin
               deb_d = deb_q + 1'b1;
               if (!from_long_q && long_hit) begin
                  lp_d        = 1'b1;
                  from_long_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESETN) begin
      if (!RESETN) begin
         state_q       <= IDLE;
         deb_q         <= '0;
         long_q        <= '0;
         from_long_q   <= 1'b0;
         held          <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         press_count   <= 8'd0;
      end else begin
         state_q       <= state_d;
         deb_q         <= deb_d;
         long_q        <= long_d;
         from_long_q   <= from_long_d;
         held          <= held_d;
         press_pulse   <= press_d;
         release_pulse <= rel_d;
         long_pulse    <= lp_d;
         press_count   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_btn_press_filter.sv
// Directed and random stimulus for btn_press_filter, checked every cycle
// against a run-length reference model of the button rules.
module tb_btn_press_filter;

   localparam int D = 4;
   localparam int L = 20;

   logic       CLOCK = 1'b0;
   logic       RESETN = 1'b0;
   logic       btn_state = 1'b0;
   logic       held, press_pulse, release_pulse, long_pulse;
   logic [7:0] press_count;

   btn_press_filter #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .CNT_W(32)) dut (
      .CLOCK         (CLOCK),
      .RESETN        (RESETN),
      .btn_state     (btn_state),
      .held          (held),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .press_count   (press_count)
   );

   always #5 CLOCK = ~CLOCK;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: button level seen two edges late, accepted after D+1
   // consecutive disagreeing samples; long event L edges after the press
   logic       q1, q2, mh, mpp, mrp, mlp;
   int         run, age;
   logic [7:0] mcnt;

   int cyc = 0;
   int n_press = 0, n_rel = 0, n_long = 0;
   int last_press = -1, last_long = -1;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      q1 = 0; q2 = 0; mh = 0; mpp = 0; mrp = 0; mlp = 0;
      run = 0; age = 0; mcnt = 0;
   endtask

   task automatic model_edge(input logic b);
      logic s;
      if (!RESETN) begin
         model_reset();
      end else begin
         s = q2; q2 = q1; q1 = b;
         mpp = 0; mrp = 0; mlp = 0;
         if (mh) age++;
         if (s != mh) run++; else run = 0;
         if (run == D + 1) begin
            run = 0;
            if (!mh) begin mh = 1; mpp = 1; mcnt++; age = 0; end
            else     begin mh = 0; mrp = 1; end
         end else if (mh && age == L) begin
            mlp = 1;
         end
      end
   endtask

   task automatic tick(input logic b);
      btn_state = b;
      @(posedge CLOCK);
      model_edge(b);
      cyc++;
      #1;
      if (press_pulse)   begin n_press++; last_press = cyc; end
      if (release_pulse) n_rel++;
      if (long_pulse)    begin n_long++; last_long = cyc; end
      chk("held", {7'd0, held}, {7'd0, mh});
      chk("press_pulse", {7'd0, press_pulse}, {7'd0, mpp});
      chk("release_pulse", {7'd0, release_pulse}, {7'd0, mrp});
      chk("long_pulse", {7'd0, long_pulse}, {7'd0, mlp});
      chk("press_count", press_count, mcnt);
   endtask

   task automatic hold(input logic b, input int n);
      for (int i = 0; i < n; i++) tick(b);
   endtask

   initial begin
      int e0, pbase, lbase, rbase;
      logic lvl;
      model_reset();

      // reset state
      #1;
      chk("rst_held", {7'd0, held}, 8'd0);
      chk("rst_count", press_count, 8'd0);
      hold(0, 3);
      #3 RESETN = 1'b1;
      hold(0, 4);

      // clean press: press_pulse after edge 6 counted from first high sample
      e0 = cyc + 1;
      hold(1, 12);
      chk("clean_latency", 8'(last_press - e0), 8'd6);
      chk("clean_count", press_count, 8'd1);
      hold(0, 12);

      // bounce rejection: 3 high, 1 low, then stable high
      pbase = n_press;
      hold(1, 3);
      tick(0);
      e0 = cyc + 1;
      hold(1, 12);
      chk("bounce_presses", 8'(n_press - pbase), 8'd1);
      chk("bounce_latency", 8'(last_press - e0), 8'd6);
      hold(0, 12);

      // long press: one long_pulse 20 edges after press, release 6 after fall
      lbase = n_long;
      rbase = n_rel;
      hold(1, 8);
      pbase = last_press;
      hold(1, 30);
      chk("long_once", 8'(n_long - lbase), 8'd1);
      chk("long_latency", 8'(last_long - pbase), 8'(L));
      hold(0, 12);
      chk("long_release", 8'(n_rel - rbase), 8'd1);

      // release glitch while held
      hold(1, 12);
      pbase = n_press;
      rbase = n_rel;
      hold(0, 2);
      hold(1, 10);
      chk("glitch_held", {7'd0, held}, 8'd1);
      chk("glitch_norel", 8'(n_rel - rbase), 8'd0);
      chk("glitch_nopress", 8'(n_press - pbase), 8'd0);
      hold(0, 12);

      // wrap: bring the total to 256 clean presses
      while (n_press < 256) begin
         hold(1, 8);
         hold(0, 8);
      end
      chk("wrap_count", press_count, 8'd0);
      chk("wrap_presses", 8'(n_press - 256), 8'd0);
      chk("wrap_releases", 8'(n_rel - 256), 8'd0);

      // random segments, occasionally long enough to go long
      lvl = 1'b0;
      for (int k = 0; k < 60; k++) begin
         lvl = ~lvl;
         if ($urandom_range(0, 7) == 0) hold(lvl, 25 + $urandom_range(0, 5));
         else                           hold(lvl, $urandom_range(1, 9));
      end
      hold(0, 12);

      // reset mid-press
      hold(1, 10);
      #2 RESETN = 1'b0;
      model_reset();
      #1;
      chk("mid_rst_held", {7'd0, held}, 8'd0);
      chk("mid_rst_count", press_count, 8'd0);
      chk("mid_rst_press", {7'd0, press_pulse}, 8'd0);
      chk("mid_rst_rel", {7'd0, release_pulse}, 8'd0);
      hold(1, 2);
      #3 RESETN = 1'b1;
      e0 = cyc + 1;
      hold(1, 10);
      chk("post_rst_latency", 8'(last_press - e0), 8'd6);
      hold(0, 12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
